// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request ops, FSM states and lane selects.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  localparam logic       HALF_HI = 1'b1;
  localparam logic [1:0] BYTE_0  = 2'd0;
  localparam logic [1:0] BYTE_1  = 2'd1;
  localparam logic [1:0] BYTE_2  = 2'd2;
  localparam logic [1:0] BYTE_3  = 2'd3;
  localparam int         TIMER_W = 10;

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_rmw(input lsu_op_e op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Lane datapath: extract/extend a sub-word for loads, insert a sub-word into the
// previously read word for SH/SB (SW passes the store data straight through).
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  lsu_op_e     i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_oldword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_wword
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = (i_addr_lo[1] == HALF_HI) ? i_rdata[31:16] : i_rdata[15:0];
    case (i_addr_lo)
      BYTE_0:  w_byte = i_rdata[7:0];
      BYTE_1:  w_byte = i_rdata[15:8];
      BYTE_2:  w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_op)
      OP_LW:   o_load = i_rdata;
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load = {16'h0000, w_half};
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load = {24'h000000, w_byte};
      default: o_load = '0;
    endcase
  end

  always_comb begin
    o_wword = i_oldword;
    case (i_op)
      OP_SW: o_wword = i_wdata;
      OP_SH: begin
        if (i_addr_lo[1] == HALF_HI) o_wword[31:16] = i_wdata[15:0];
        else                         o_wword[15:0]  = i_wdata[15:0];
      end
      OP_SB: begin
        case (i_addr_lo)
          BYTE_0:  o_wword[7:0]   = i_wdata[7:0];
          BYTE_1:  o_wword[15:8]  = i_wdata[7:0];
          BYTE_2:  o_wword[23:16] = i_wdata[7:0];
          BYTE_3:  o_wword[31:24] = i_wdata[7:0];
          default: o_wword = i_oldword;
        endcase
      end
      default: o_wword = i_oldword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage against a word-only bus: sub-word loads by lane extraction,
// sub-word stores by read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // state | meaning
  // IDLE  | ready, waiting for a request
  // RD    | mem_rd held: load, or read half of an SH/SB
  // WR    | mem_wr held: SW, or write half of an SH/SB
  // RESP  | one-cycle response to writeback

  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  lsu_state_e         r_state;
  lsu_op_e            r_op;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rword;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [TIMER_W-1:0] r_cnt;

  lsu_op_e     w_req_op;
  logic        w_trap;
  logic        w_timeout;
  logic [31:0] w_load;
  logic [31:0] w_wword;

  assign w_req_op = lsu_op_e'(req_op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_req_op, req_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  assign w_timeout = !mem_ack && (r_cnt == TO_LAST);

  lsu_lane_merge u_lane_merge (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (mem_rdata),
    .i_oldword (r_rword),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_wword   (w_wword)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rword <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= w_req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            if (w_trap) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else if (w_req_op == OP_SW) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            r_cnt <= '0;
            if (is_rmw(r_op)) begin
              r_rword <= mem_rdata;
              r_state <= ST_WR;
            end else begin
              r_rdata <= w_load;
              r_state <= ST_RESP;
            end
          end else if (w_timeout) begin
            // a timed-out RMW read never reaches WR, so no write is issued
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_rd     = (r_state == ST_RD);
  assign mem_wr     = (r_state == ST_WR);
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = mem_wr ? w_wword : '0;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_err   = resp_valid & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory responder with programmable ack
// delay, expected responses queued at issue and compared when resp_valid arrives.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic [31:0] mem [0:255];
  int rd_delay = 0;
  int wr_delay = 0;
  int wait_cnt = 0;
  int wr_count = 0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  int obs_lat, obs_rd_cyc, obs_wr_cyc, obs_wr_first, obs_gap;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic obs_err, obs_got, obs_both, obs_wstable, obs_acc, obs_seen;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ack = (mem_rd && wait_cnt >= rd_delay) || (mem_wr && wait_cnt >= wr_delay);

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
    if (mem_wr && mem_ack) wr_count <= wr_count + 1;
  end

  // Called at a negedge; returns #1 after the acceptance edge with req_* scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic push);
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    obs_gap = 0; obs_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        @(posedge clk);
        obs_acc = 1'b1;
        break;
      end
      @(negedge clk);
      obs_gap++;
    end
    #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (push) begin
      e.rdata = exp_rdata; e.err = exp_err;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_resp(input int budget);
    obs_lat = 0; obs_rd_cyc = 0; obs_wr_cyc = 0; obs_wr_first = 0;
    obs_addr = '0; obs_wdata = '0; obs_rdata = '0;
    obs_err = 1'b0; obs_got = 1'b0; obs_both = 1'b0; obs_wstable = 1'b1; obs_seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      obs_lat = i;
      if ((mem_rd || mem_wr) && !obs_seen) begin obs_addr = mem_addr; obs_seen = 1'b1; end
      if (mem_rd) obs_rd_cyc++;
      if (mem_wr) begin
        if (obs_wr_cyc == 0) begin obs_wr_first = i; obs_wdata = mem_wdata; end
        else if (mem_wdata !== obs_wdata) obs_wstable = 1'b0;
        obs_wr_cyc++;
      end
      if (mem_rd && mem_wr) obs_both = 1'b1;
      if (resp_valid) begin
        obs_got = 1'b1; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    n_checks++; if ({mem_rd, mem_wr, resp_valid, resp_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes: got rd/wr/valid/err %b expected 0000", {mem_rd, mem_wr, resp_valid, resp_err}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_data: got addr %h wdata %h rdata %h expected all 0", mem_addr, mem_wdata, resp_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    exp_t e;
    mem[8'h40] = 32'hDEADBEEF;
    issue(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got) begin n_fail++; $display("FAIL lw_resp: no resp_valid within 40 cycles"); end
    n_checks++; if (obs_rdata !== e.rdata || obs_err !== e.err) begin n_fail++; $display("FAIL lw_data: got %h err %b expected %h err %b", obs_rdata, obs_err, e.rdata, e.err); end
    n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", obs_lat); end
    n_checks++; if (obs_addr !== 32'h100 || obs_rd_cyc !== 1 || obs_wr_cyc !== 0) begin n_fail++; $display("FAIL lw_bus: got addr %h rd %0d wr %0d expected 100 1 0", obs_addr, obs_rd_cyc, obs_wr_cyc); end
  endtask

  task automatic test_subword_loads();
    exp_t e;
    logic [2:0]  t_op   [5] = '{OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LH};
    logic [31:0] t_addr [5] = '{32'h102, 32'h102, 32'h101, 32'h103, 32'h100};
    logic [31:0] t_word [5] = '{32'h80011234, 32'h80011234, 32'h0000F000, 32'h80000000, 32'h80011234};
    logic [31:0] t_exp  [5] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFFF0, 32'h00000080, 32'h00001234};
    for (int i = 0; i < 5; i++) begin
      mem[8'h40] = t_word[i];
      issue(t_op[i], t_addr[i], 32'h0, t_exp[i], 1'b0, 1'b1);
      wait_resp(40);
      e = sb_q.pop_front();
      n_checks++;
      if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err || obs_lat !== 2) begin
        n_fail++;
        $display("FAIL subload_%0d: got valid %b rdata %h err %b lat %0d expected rdata %h err %b lat 2",
                 i, obs_got, obs_rdata, obs_err, obs_lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_sb_rmw();
    exp_t e;
    int wc;
    mem[8'h80] = 32'h11223344;
    wc = wr_count;
    issue(OP_SB, 32'h203, 32'h123456AA, 32'h0, 1'b0, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_lat !== 3) begin n_fail++; $display("FAIL sb_latency: got valid %b lat %0d expected 3", obs_got, obs_lat); end
    n_checks++; if (obs_rd_cyc !== 1 || obs_wr_first !== 2 || obs_wr_cyc !== 1 || obs_addr !== 32'h200) begin n_fail++; $display("FAIL sb_bus: got rd %0d wr_first %0d wr %0d addr %h expected 1 2 1 200", obs_rd_cyc, obs_wr_first, obs_wr_cyc, obs_addr); end
    n_checks++; if (obs_wdata !== 32'hAA223344) begin n_fail++; $display("FAIL sb_wdata: got %h expected aa223344", obs_wdata); end
    n_checks++; if (obs_rdata !== e.rdata || obs_err !== e.err || obs_both !== 1'b0) begin n_fail++; $display("FAIL sb_resp: got rdata %h err %b overlap %b expected %h %b 0", obs_rdata, obs_err, obs_both, e.rdata, e.err); end
    n_checks++; if (wr_count - wc !== 1) begin n_fail++; $display("FAIL sb_writes: got %0d expected 1", wr_count - wc); end
  endtask

  task automatic test_sh_read_wait();
    exp_t e;
    mem[8'h40] = 32'hCAFEBABE;
    rd_delay = 3;
    issue(OP_SH, 32'h102, 32'hFFFF5678, 32'h0, 1'b0, 1'b1);
    wait_resp(40);
    rd_delay = 0;
    e = sb_q.pop_front();
    n_checks++; if (obs_rd_cyc !== 4 || obs_wr_cyc !== 1 || obs_lat !== 6) begin n_fail++; $display("FAIL sh_wait_timing: got rd %0d wr %0d lat %0d expected 4 1 6", obs_rd_cyc, obs_wr_cyc, obs_lat); end
    n_checks++; if (obs_wdata !== 32'h5678BABE) begin n_fail++; $display("FAIL sh_wdata: got %h expected 5678babe", obs_wdata); end
    n_checks++; if (!obs_got || obs_rdata !== e.rdata || obs_err !== e.err) begin n_fail++; $display("FAIL sh_resp: got valid %b rdata %h err %b expected %h %b", obs_got, obs_rdata, obs_err, e.rdata, e.err); end
  endtask

  task automatic test_timeout();
    exp_t e;
    int wc;
    wc = wr_count;
    wr_delay = 1000;
    issue(OP_SW, 32'h300, 32'h12345678, 32'h0, 1'b1, 1'b1);
    wait_resp(40);
    wr_delay = 0;
    e = sb_q.pop_front();
    n_checks++; if (obs_wr_cyc !== TO || obs_lat !== TO + 1) begin n_fail++; $display("FAIL sw_timeout_timing: got wr %0d lat %0d expected %0d %0d", obs_wr_cyc, obs_lat, TO, TO + 1); end
    n_checks++; if (!obs_got || obs_err !== e.err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL sw_timeout_resp: got valid %b err %b rdata %h expected err %b rdata %h", obs_got, obs_err, obs_rdata, e.err, e.rdata); end
    n_checks++; if (obs_wdata !== 32'h12345678 || obs_wstable !== 1'b1) begin n_fail++; $display("FAIL sw_wdata: got %h stable %b expected 12345678 1", obs_wdata, obs_wstable); end
    rd_delay = 1000;
    issue(OP_SB, 32'h203, 32'h000000AA, 32'h0, 1'b1, 1'b1);
    wait_resp(40);
    rd_delay = 0;
    e = sb_q.pop_front();
    n_checks++; if (obs_rd_cyc !== TO || obs_wr_cyc !== 0 || obs_lat !== TO + 1) begin n_fail++; $display("FAIL rmw_timeout_timing: got rd %0d wr %0d lat %0d expected %0d 0 %0d", obs_rd_cyc, obs_wr_cyc, obs_lat, TO, TO + 1); end
    n_checks++; if (!obs_got || obs_err !== e.err || obs_rdata !== e.rdata || wr_count !== wc) begin n_fail++; $display("FAIL rmw_timeout_resp: got valid %b err %b rdata %h writes %0d expected err %b rdata %h writes 0", obs_got, obs_err, obs_rdata, wr_count - wc, e.err, e.rdata); end
  endtask

  task automatic test_reset_mid();
    int wc, nresp;
    logic seen;
    // Reset while an SH sits in WR
    wr_delay = 1000;
    issue(OP_SH, 32'h102, 32'h00005678, 32'h0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wr) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_wr: got no mem_wr within 20 cycles expected mem_wr"); end
    rst = 1'b1; wr_delay = 0; wc = wr_count;
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr: got wr %b rd %b ready %b valid %b expected 0 0 1 0", mem_wr, mem_rd, req_ready, resp_valid); end
    rst = 1'b0;
    nresp = 0;
    repeat (8) begin @(negedge clk); if (resp_valid) nresp++; end
    n_checks++; if (nresp !== 0 || wr_count - wc > 1) begin n_fail++; $display("FAIL rstmid_after_wr: got resp %0d writes %0d expected 0 and at most 1", nresp, wr_count - wc); end
    // Reset while an SB sits in RD: no write may follow
    rd_delay = 1000;
    issue(OP_SB, 32'h203, 32'h000000AA, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1; rd_delay = 0; wc = wr_count;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd: got rd %b wr %b ready %b expected 0 0 1", mem_rd, mem_wr, req_ready); end
    rst = 1'b0;
    nresp = 0;
    repeat (8) begin @(negedge clk); if (resp_valid) nresp++; end
    n_checks++; if (nresp !== 0 || wr_count !== wc) begin n_fail++; $display("FAIL rstmid_after_rd: got resp %0d writes %0d expected 0 0", nresp, wr_count - wc); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mem[8'h41] = 32'h01020304;
    issue(OP_LW, 32'h104, 32'h0, 32'h01020304, 1'b0, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_first: got valid %b rdata %h expected %h", obs_got, obs_rdata, e.rdata); end
    issue(OP_LBU, 32'h105, 32'h0, 32'h00000003, 1'b0, 1'b1);
    n_checks++; if (!obs_acc || obs_gap !== 1) begin n_fail++; $display("FAIL b2b_accept: got accepted %b after %0d cycles expected 1 after 1", obs_acc, obs_gap); end
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_rdata !== e.rdata || obs_lat !== 2) begin n_fail++; $display("FAIL b2b_second: got valid %b rdata %h lat %0d expected %h lat 2", obs_got, obs_rdata, obs_lat, e.rdata); end
  endtask

  task automatic test_misalign();
    exp_t e;
    mem[8'h40] = 32'hDEADBEEF;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_lat !== 1 || obs_rd_cyc !== 0 || obs_wr_cyc !== 0) begin n_fail++; $display("FAIL misalign_trap_timing: got valid %b lat %0d rd %0d wr %0d expected 1 1 0 0", obs_got, obs_lat, obs_rd_cyc, obs_wr_cyc); end
    n_checks++; if (obs_err !== e.err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL misalign_trap_resp: got err %b rdata %h expected %b %h", obs_err, obs_rdata, e.err, e.rdata); end
`else
    issue(OP_LW, 32'h101, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_lat !== 2 || obs_addr !== 32'h100) begin n_fail++; $display("FAIL misalign_lw_bus: got valid %b lat %0d addr %h expected 1 2 100", obs_got, obs_lat, obs_addr); end
    n_checks++; if (obs_err !== e.err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL misalign_lw_resp: got err %b rdata %h expected %b %h", obs_err, obs_rdata, e.err, e.rdata); end
    mem[8'h40] = 32'h80011234;
    issue(OP_LH, 32'h103, 32'h0, 32'hFFFF8001, 1'b0, 1'b1);
    wait_resp(40);
    e = sb_q.pop_front();
    n_checks++; if (!obs_got || obs_err !== e.err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL misalign_lh_resp: got valid %b err %b rdata %h expected %b %h", obs_got, obs_err, obs_rdata, e.err, e.rdata); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_lw();
    test_subword_loads();
    test_sb_rmw();
    test_sh_read_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
    $fatal(1);
  end

endmodule
